// File: rtl/refclk_nco_gen.sv
// refclk_nco_gen: phase-accumulator (NCO) generator for the low-frequency
// reference clock and a 1 Hz pulse, derived from the fast system clock.
// A runtime signed trim corrects ppm error and is applied on whole refclk periods.
module refclk_nco_gen #(
   parameter int unsigned SYS_CLK_HZ     = 10_000_000,
   parameter int unsigned REF_CLK_HZ     = 32_768,
   parameter int unsigned ACC_WIDTH      = 24,
   parameter int unsigned TRIM_WIDTH     = 8,
   parameter int unsigned PPS_HIGH_EDGES = 3_277
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_en,
   input  logic [TRIM_WIDTH-1:0] i_trim,
   input  logic                  i_trim_load,
   output logic                  o_refclk,
   output logic                  o_refclk_stb,
   output logic                  o_pps,
   output logic                  o_pps_stb
);

   // Nominal increment: two carries per refclk period, rounded to nearest.
   localparam logic [63:0] INC_NOM =
      ((64'd1 << ACC_WIDTH) * 64'(2 * REF_CLK_HZ) + 64'(SYS_CLK_HZ / 2)) / 64'(SYS_CLK_HZ);
   localparam logic [ACC_WIDTH-1:0] INC_ACC = INC_NOM[ACC_WIDTH-1:0];

   localparam int unsigned CNT_W = (REF_CLK_HZ > 1) ? $clog2(REF_CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_CLK_HZ - 1);
   localparam logic [CNT_W-1:0] PPS_CNT  = CNT_W'(PPS_HIGH_EDGES);

   // Reject configurations that cannot produce a valid increment or pulse width.
   if (INC_NOM == 64'd0 || INC_NOM >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
      $error("refclk_nco_gen: INC_NOM out of range for ACC_WIDTH");
   end
   if (TRIM_WIDTH > ACC_WIDTH) begin : g_bad_trim
      $error("refclk_nco_gen: TRIM_WIDTH must not exceed ACC_WIDTH");
   end
   if (PPS_HIGH_EDGES < 1 || PPS_HIGH_EDGES > REF_CLK_HZ - 1) begin : g_bad_pps
      $error("refclk_nco_gen: PPS_HIGH_EDGES must be in 1..REF_CLK_HZ-1");
   end

   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
   logic [TRIM_WIDTH-1:0] trim_pending_q, trim_pending_d;
   logic [TRIM_WIDTH-1:0] trim_active_q, trim_active_d;
   logic                  refclk_q, refclk_d;
   logic                  refclk_stb_q, refclk_stb_d;
   logic                  pps_q, pps_d;
   logic                  pps_stb_q, pps_stb_d;

   logic [ACC_WIDTH-1:0]  inc_eff;
   logic [ACC_WIDTH:0]    sum;
   logic                  carry;
   logic                  rise;
   logic [CNT_W-1:0]      edge_inc;

   // Effective increment uses the sign-extended active trim; sum keeps the carry bit.
   always_comb begin
      inc_eff  = INC_ACC + ACC_WIDTH'($signed(trim_active_q));
      sum      = {1'b0, acc_q} + {1'b0, inc_eff};
      carry    = sum[ACC_WIDTH];
      rise     = i_en & carry & ~refclk_q;
      edge_inc = edge_cnt_q + 1'b1;
   end

   // Next-state: accumulate when enabled, toggle on carry, count rising edges for the pulse.
   always_comb begin
      acc_d          = acc_q;
      edge_cnt_d     = edge_cnt_q;
      trim_pending_d = trim_pending_q;
      trim_active_d  = trim_active_q;
      refclk_d       = refclk_q;
      refclk_stb_d   = 1'b0;
      pps_d          = pps_q;
      pps_stb_d      = 1'b0;

      // Loading works regardless of enable; the old pending value is what a
      // same-cycle rise applies.
      if (i_trim_load) begin
         trim_pending_d = i_trim;
      end

      if (i_en) begin
         acc_d = sum[ACC_WIDTH-1:0];
         if (carry) begin
            refclk_d = ~refclk_q;
         end
      end

      if (rise) begin
         refclk_stb_d  = 1'b1;
         trim_active_d = trim_pending_q;
         if (edge_cnt_q == CNT_LAST) begin
            edge_cnt_d = '0;
            pps_d      = 1'b1;
            pps_stb_d  = 1'b1;
         end else begin
            edge_cnt_d = edge_inc;
            if (edge_inc == PPS_CNT) begin
               pps_d = 1'b0;
            end
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         acc_q          <= '0;
         edge_cnt_q     <= '0;
         trim_pending_q <= '0;
         trim_active_q  <= '0;
         refclk_q       <= 1'b0;
         refclk_stb_q   <= 1'b0;
         pps_q          <= 1'b0;
         pps_stb_q      <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         edge_cnt_q     <= edge_cnt_d;
         trim_pending_q <= trim_pending_d;
         trim_active_q  <= trim_active_d;
         refclk_q       <= refclk_d;
         refclk_stb_q   <= refclk_stb_d;
         pps_q          <= pps_d;
         pps_stb_q      <= pps_stb_d;
      end
   end

   assign o_refclk     = refclk_q;
   assign o_refclk_stb = refclk_stb_q;
   assign o_pps        = pps_q;
   assign o_pps_stb    = pps_stb_q;

endmodule
